// File: rtl/img2col_pkg.sv
// Shared types and constants for the im2col patch reader.
// Element width and RAM address width default to 16 and 8 when the build does not define them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

package img2col_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic patch_last;
        logic frame_last;
    } tag_t;

endpackage

// File: rtl/img2col_patch_reader_if.sv
// Output element stream of the patch reader (valid/ready with patch/frame tags).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface img2col_patch_reader_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) ();
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_patch_last;
    logic                  m_frame_last;

    modport master (output m_valid, m_data, m_patch_last, m_frame_last, input m_ready);
    modport slave  (input m_valid, m_data, m_patch_last, m_frame_last, output m_ready);
endinterface

// File: rtl/img2col_skid_fifo.sv
// Two-entry FIFO with registered head; a push and a pop in the same cycle are both honoured.
module img2col_skid_fifo
    import img2col_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign rd_ok = pop && (count != 2'd0);
    assign wr_ok = push && ((count != 2'(FIFO_DEPTH)) || rd_ok);
    assign dout  = mem[rd_ptr];
    assign valid = (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_ok) rd_ptr <= ~rd_ptr;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/img2col_patch_reader.sv
// Walks an HxW tensor in im2col order (KxK window, stride 1, no padding), reading the
// single-port RAM and streaming elements through a credit-protected 2-entry FIFO.
//   state | meaning
//   IDLE  | waiting for start; config latched on start
//   ISSUE | issuing RAM reads while FIFO credit allows
//   DRAIN | all reads issued; waiting for the frame_last handshake
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module img2col_patch_reader
    import img2col_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int K          = 3,
    parameter int DIM_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  cfg_base,
    input  logic [DIM_W-1:0]      cfg_h,
    input  logic [DIM_W-1:0]      cfg_w,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    img2col_patch_reader_if.master m,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int PW = DATA_WIDTH + $bits(tag_t);
    localparam logic [DIM_W-1:0] K_D  = DIM_W'(K);
    localparam logic [DIM_W-1:0] K_M1 = DIM_W'(K - 1);

    state_t               state, state_nx;
    logic [ADDR_SIZE-1:0] base_q, w_a, oy_row, row_off;
    logic [DIM_W-1:0]     oy_max, ox_max, oy, ox, ky, kx;
    logic                 inflight, pop, start_ok, bad_start, last_issue, frame_end;
    logic [2:0]           occupancy;
    logic [1:0]           fifo_count;
    logic [PW-1:0]        head;
    tag_t                 tag_issue, tag_d, head_tag;

    assign start_ok  = (state == IDLE) && start;
    assign bad_start = start_ok && ((cfg_h < K_D) || (cfg_w < K_D));
    assign pop       = m.m_valid && m.m_ready;

    assign tag_issue.patch_last = (ky == K_M1) && (kx == K_M1);
    assign tag_issue.frame_last = tag_issue.patch_last && (oy == oy_max) && (ox == ox_max);

    // Credit: entries held plus the read in flight, minus this cycle's pop, must leave a slot.
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight};
    assign ram_en    = (state == ISSUE) && (occupancy < (3'd2 + {2'b0, pop}));
    assign ram_we    = 1'b0;
    assign ram_addr  = base_q + row_off + ADDR_SIZE'(ox) + ADDR_SIZE'(kx);

    assign last_issue = ram_en && tag_issue.frame_last;
    assign frame_end  = pop && m.m_frame_last;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok && !bad_start) state_nx = ISSUE;
            ISSUE:   if (last_issue) state_nx = DRAIN;
            DRAIN:   if (frame_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            inflight <= 1'b0;
            tag_d    <= '0;
        end else begin
            state    <= state_nx;
            done     <= bad_start || ((state == DRAIN) && frame_end);
            err      <= bad_start;
            inflight <= ram_en;
            tag_d    <= tag_issue;
        end
    end

    // row_off tracks (oy+ky)*w and oy_row tracks oy*w, so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            w_a     <= '0;
            oy_max  <= '0;
            ox_max  <= '0;
            oy      <= '0;
            ox      <= '0;
            ky      <= '0;
            kx      <= '0;
            oy_row  <= '0;
            row_off <= '0;
        end else if (start_ok) begin
            base_q  <= cfg_base;
            w_a     <= ADDR_SIZE'(cfg_w);
            oy_max  <= cfg_h - K_D;
            ox_max  <= cfg_w - K_D;
            oy      <= '0;
            ox      <= '0;
            ky      <= '0;
            kx      <= '0;
            oy_row  <= '0;
            row_off <= '0;
        end else if (ram_en) begin
            if (kx != K_M1) begin
                kx <= kx + DIM_W'(1);
            end else begin
                kx <= '0;
                if (ky != K_M1) begin
                    ky      <= ky + DIM_W'(1);
                    row_off <= row_off + w_a;
                end else begin
                    ky <= '0;
                    if (ox != ox_max) begin
                        ox      <= ox + DIM_W'(1);
                        row_off <= oy_row;
                    end else begin
                        ox      <= '0;
                        oy      <= oy + DIM_W'(1);
                        oy_row  <= oy_row + w_a;
                        row_off <= oy_row + w_a;
                    end
                end
            end
        end
    end

    img2col_skid_fifo #(.WIDTH(PW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   ({ram_dout, tag_d}),
        .pop   (pop),
        .dout  (head),
        .valid (m.m_valid),
        .count (fifo_count)
    );

    assign head_tag       = tag_t'(head[$bits(tag_t)-1:0]);
    assign m.m_data       = head[PW-1:$bits(tag_t)];
    assign m.m_patch_last = head_tag.patch_last;
    assign m.m_frame_last = head_tag.frame_last;

endmodule

// File: tb/tb_img2col_patch_reader.sv
// Directed bench for img2col_patch_reader: a RAM model with mem[i]=i, a reference im2col walk,
// and cycle-accurate checks on latency, tags, stalls, wrap, error and reset behaviour.
module tb_img2col_patch_reader;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int KK = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] cfg_base;
    logic [7:0]    cfg_h, cfg_w;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic          busy, done, err;
    logic          rand_ready = 1'b0;

    img2col_patch_reader_if #(.DATA_WIDTH(DW)) sif ();

    img2col_patch_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .K(KK), .DIM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_h(cfg_h),
        .cfg_w(cfg_w), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .m(sif.master), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [256];
    always @(posedge clk) if (ram_en) ram_dout <= ram[ram_addr];

    initial begin
        sif.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sif.m_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: element capture, timing markers and stall/occupancy/write-enable watchers.
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] prev_elem = '0;
    logic        prev_stall = 1'b0, busy_prev = 1'b0;
    int cyc = 0, c0 = 0, first_en_rel = -1, first_valid_rel = -1;
    int en_cnt = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
    int stall_viol = 0, fifo_over = 0, we_viol = 0;
    int n_chk = 0, n_bad = 0;

    wire [17:0] cur_elem = {sif.m_patch_last, sif.m_frame_last, sif.m_data};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        busy_prev <= busy;
        if (busy && !busy_prev) begin
            c0 <= cyc;
            first_en_rel <= ram_en ? 1 : -1;
            first_valid_rel <= -1;
            got_q.delete();
        end else begin
            if (ram_en && first_en_rel < 0) first_en_rel <= cyc - c0 + 1;
            if (sif.m_valid && first_valid_rel < 0) first_valid_rel <= cyc - c0 + 1;
        end
        if (ram_en) en_cnt <= en_cnt + 1;
        if (ram_we) we_viol <= we_viol + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (sif.m_valid && sif.m_ready) begin
            got_q.push_back(cur_elem);
            last_hs_cyc <= cyc;
        end
        if (prev_stall && rst_n && cur_elem != prev_elem) stall_viol <= stall_viol + 1;
        prev_stall <= rst_n && sif.m_valid && !sif.m_ready;
        prev_elem  <= cur_elem;
        if (dut.u_fifo.count > 2'd2) fifo_over <= fifo_over + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_exp(input int base, input int h, input int w);
        exp_q.delete();
        for (int oy = 0; oy <= h - KK; oy++)
            for (int ox = 0; ox <= w - KK; ox++)
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++) begin
                        int  a;
                        logic pl, fl;
                        a  = (base + (oy + ky) * w + ox + kx) % 256;
                        pl = (ky == KK - 1) && (kx == KK - 1);
                        fl = pl && (oy == h - KK) && (ox == w - KK);
                        exp_q.push_back({pl, fl, 16'(a)});
                    end
    endfunction

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // Start is presented for one cycle; config is scrambled afterwards to prove it was latched.
    task automatic start_frame(input int base, input int h, input int w);
        @(posedge clk);
        #1;
        cfg_base = AW'(base);
        cfg_h = 8'(h);
        cfg_w = 8'(w);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_base = 8'hA5;
        cfg_h = 8'd1;
        cfg_w = 8'd200;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!done && n < limit);
        if (!done) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    logic [DW-1:0] p0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [DW-1:0] p1[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    initial begin
        int en0, d0, n;
        for (int i = 0; i < 256; i++) ram[i] = DW'(i);
        rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_h = '0; cfg_w = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {sif.m_valid, sif.m_patch_last, sif.m_frame_last, busy, done, err,
                              ram_en, ram_we, sif.m_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4x4, K=3, always ready
        build_exp(0, 4, 4);
        start_frame(0, 4, 4);
        wait_done("basic", 300);
        check_stream("basic");
        for (int i = 0; i < 9; i++) if (got_q.size() > 18) begin
            chk($sformatf("patch0[%0d]", i), got_q[i][15:0], p0[i]);
            chk($sformatf("patch1[%0d]", i), got_q[9 + i][15:0], p1[i]);
        end
        if (got_q.size() == 36) begin
            chk("final_elem", got_q[35], {1'b1, 1'b1, 16'd15});
            chk("patch0_last_tag", got_q[8][17:16], 2'b10);
        end
        chk("first_en_cycle", first_en_rel, 1);
        chk("first_valid_cycle", first_valid_rel, 3);
        chk("done_after_last_hs", done_cyc, last_hs_cyc + 1);
        chk("basic_reads", en_cnt, 36);
        chk("basic_err_low", err, 0);
        @(negedge clk);
        #1;
        chk("done_one_pulse", {done, busy}, 0);

        // Same frame with 30% ready duty
        rand_ready = 1'b1;
        start_frame(0, 4, 4);
        wait_done("stall", 2000);
        rand_ready = 1'b0;
        check_stream("stall");
        chk("stall_hold", stall_viol, 0);
        chk("fifo_le2", fifo_over, 0);

        // Too-small tensor: err+done at cycle 1, no reads, idle
        en0 = en_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        cfg_base = 8'd0; cfg_h = 8'd2; cfg_w = 8'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_cycle1", {err, done, busy}, 3'b110);
        @(posedge clk);
        #1;
        chk("err_cycle2", {err, done, busy}, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        chk("err_no_reads", en_cnt - en0, 0);
        chk("err_done_count", done_cnt - d0, 1);

        // Address wrap
        build_exp(254, 3, 3);
        start_frame(254, 3, 3);
        wait_done("wrap", 300);
        check_stream("wrap");
        if (got_q.size() > 2) chk("wrap_third_addr0", got_q[2][15:0], 0);

        // Reset after 10 elements, then a clean full frame
        build_exp(7, 4, 5);
        start_frame(7, 4, 5);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (got_q.size() < 10 && n < 300);
        chk("mid_reached10", got_q.size() >= 10, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {sif.m_valid, sif.m_patch_last, sif.m_frame_last, busy, done, err,
                                 ram_en, sif.m_data}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_no_done", done_cnt - d0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(7, 4, 5);
        wait_done("after_reset", 400);
        check_stream("after_reset");

        // Start during ISSUE is ignored; start in the done cycle launches the next frame
        build_exp(0, 4, 4);
        start_frame(0, 4, 4);
        repeat (5) @(posedge clk);
        #1;
        cfg_base = 8'd100; cfg_h = 8'd5; cfg_w = 8'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", 300);
        check_stream("ignore");
        cfg_base = 8'd5; cfg_h = 8'd3; cfg_w = 8'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_busy", busy, 1);
        build_exp(5, 3, 4);
        wait_done("restart", 300);
        check_stream("restart");
        chk("restart_first_en", first_en_rel, 1);
        chk("ram_we_low", we_viol, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
